// File: rtl/ssd_scan_mux_pkg.sv
// ssd_pkg: shared constants for the seven-segment scan driver.
//   SEG_LUT   : active-low segment patterns for nibbles 0..F (bit order g..a)
//   SEG_OFF   : all segments dark
//   cnt_width : width of the prescaler / digit-index counters (min 1 bit)
package ssd_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Entry n is the pattern for nibble n; bit 0 = segment a, bit 6 = segment g.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'b0001110,   // F
      7'b0000110,   // E
      7'b0100001,   // d
      7'b1000110,   // C
      7'b0000011,   // b
      7'b0001000,   // A
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   // clog2 clamped to 1 so a divide-by-1 prescaler or single digit still
   // gets a legal 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ssd_scan_mux_if.sv
// ssd_scan_mux_if: data/load bus into the scan driver and the display pins out.
//   value/dp/blank/load : frame data and capture strobe (master -> slave)
//   seg/dp_n/an         : active-low segment, decimal point and anode pins
//   frame_tick          : one-cycle pulse at each frame boundary
interface ssd_scan_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    load;
   logic [6:0]              seg;
   logic                    dp_n;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_tick;

   modport master (
      output value, dp, blank, load,
      input  seg, dp_n, an, frame_tick
   );

   modport slave (
      input  value, dp, blank, load,
      output seg, dp_n, an, frame_tick
   );
endinterface

// File: rtl/ssd_hex_dec.sv
// ssd_hex_dec: combinational nibble -> active-low seven-segment decoder.
//   nib   : hex digit
//   blank : force all segments dark
//   seg   : segments a..g on bits 0..6, active-low
module ssd_hex_dec
   import ssd_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_OFF : SEG_LUT[nib];

endmodule

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexed common-anode seven-segment display driver.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : ssd_scan_mux_if.slave (value/dp/blank/load in; seg/dp_n/an/frame_tick out)
// Parameters: NUM_DIGITS (1..8), REFRESH_DIV cycles per digit slot, GUARD
// dark cycles at the start of every slot (0 = no gap).
// Build option: define SSD_LZB_EN for leading-zero blanking of the displayed
// value (digit 0 is never blanked by it).
// All outputs are registered and reflect the scan state of the previous cycle.
module ssd_scan_mux
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   ssd_scan_mux_if.slave   bus
);

   localparam int CW = cnt_width(REFRESH_DIV);
   localparam int IW = cnt_width(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic          slot_end;
   logic          frame_end;
   logic          in_guard;

   logic [4*NUM_DIGITS-1:0] sh_value, ds_value;
   logic [NUM_DIGITS-1:0]   sh_dp, ds_dp;
   logic [NUM_DIGITS-1:0]   sh_blank, ds_blank;
   logic                    pending;

   logic [NUM_DIGITS-1:0]   lzb;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [6:0]              cur_seg;
   logic [NUM_DIGITS-1:0]   an_lit;

   logic [6:0]              seg_q;
   logic                    dp_n_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic                    tick_q;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   // A zero-width guard would make "cnt < 0" a constant compare; split it out.
   generate
      if (GUARD == 0) begin : g_noguard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (cnt < CW'(GUARD));
      end
   endgenerate

   // ---------------------------------------------------------------- scan
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= frame_end ? '0 : idx + IW'(1);
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // ----------------------------------------------------------- load path
   // Shadow takes every load; display only changes at a frame boundary so a
   // frame never mixes two values. A load on the boundary cycle itself
   // bypasses the shadow and leaves nothing pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_value <= '0;
         sh_dp    <= '0;
         sh_blank <= '0;
         ds_value <= '0;
         ds_dp    <= '0;
         ds_blank <= '0;
         pending  <= 1'b0;
      end else begin
         if (bus.load) begin
            sh_value <= bus.value;
            sh_dp    <= bus.dp;
            sh_blank <= bus.blank;
         end
         if (frame_end) begin
            if (bus.load) begin
               ds_value <= bus.value;
               ds_dp    <= bus.dp;
               ds_blank <= bus.blank;
            end else if (pending) begin
               ds_value <= sh_value;
               ds_dp    <= sh_dp;
               ds_blank <= sh_blank;
            end
            pending <= 1'b0;
         end else if (bus.load) begin
            pending <= 1'b1;
         end
      end
   end

   // ------------------------------------------------ leading-zero blanking
`ifdef SSD_LZB_EN
   // Walk down from the top digit; blank zeros until the first nonzero one.
   always_comb begin
      logic run;
      run = 1'b1;
      lzb = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if (run && (ds_value[4*k +: 4] == 4'h0)) lzb[k] = 1'b1;
         else                                    run    = 1'b0;
      end
   end
`else
   assign lzb = '0;
`endif

   // ------------------------------------------------------- digit select
   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      an_lit    = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_nib   = ds_value[4*k +: 4];
            cur_dp    = ds_dp[k];
            cur_blank = ds_blank[k] | lzb[k];
            an_lit[k] = 1'b0;
         end
      end
   end

   ssd_hex_dec u_dec (
      .nib   (cur_nib),
      .blank (cur_blank),
      .seg   (cur_seg)
   );

   // ------------------------------------------------------------ outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q   <= '1;
         seg_q  <= SEG_OFF;
         dp_n_q <= 1'b1;
         tick_q <= 1'b0;
      end else begin
         tick_q <= frame_end;
         if (in_guard) begin
            an_q   <= '1;
            seg_q  <= SEG_OFF;
            dp_n_q <= 1'b1;
         end else begin
            an_q   <= an_lit;
            seg_q  <= cur_seg;
            dp_n_q <= ~cur_dp;
         end
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp_n       = dp_n_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// tb_ssd_scan_mux: scoreboard bench for ssd_scan_mux (4 digits, 8-cycle
// slots, 2-cycle guard) plus a divide-by-1 / no-guard instance.
module tb_ssd_scan_mux;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int GD = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ssd_scan_mux_if #(.NUM_DIGITS(ND)) bus  ();
   ssd_scan_mux_if #(.NUM_DIGITS(ND)) fbus ();

   ssd_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD)) dut (
      .clk (clk), .rst_n (rst_n), .bus (bus)
   );
   ssd_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(1), .GUARD(0)) fdut (
      .clk (clk), .rst_n (rst_n), .bus (fbus)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp_n;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // observations of one frame
   logic [3:0] o_an[ND], o_anb[ND], g_an[ND];
   logic [6:0] o_sa[ND], o_sb[ND], g_seg[ND];
   logic       o_da[ND], o_db[ND], g_dp[ND];
   logic       tick_end;

   function automatic logic [6:0] hex2seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [3:0] lzb_mask(input logic [15:0] v);
      logic [3:0] m;
      m = 4'b0000;
`ifdef SSD_LZB_EN
      if (v[15:12] == 4'h0) begin
         m[3] = 1'b1;
         if (v[11:8] == 4'h0) begin
            m[2] = 1'b1;
            if (v[7:4] == 4'h0) m[1] = 1'b1;
         end
      end
`endif
      return m;
   endfunction

   function automatic void push_frame(input logic [15:0] v, input logic [3:0] d,
                                      input logic [3:0] b);
      logic [3:0] m;
      exp_t e;
      m = lzb_mask(v);
      for (int s = 0; s < ND; s++) begin
         e.an   = ~(4'b0001 << s);
         e.seg  = (b[s] | m[s]) ? 7'h7F : hex2seg(v[4*s +: 4]);
         e.dp_n = ~d[s];
         sb.push_back(e);
      end
   endfunction

   // Starts on the negedge where frame_tick is high; ends 32 negedges later,
   // which is the next frame_tick.
   task automatic capture_frame();
      for (int s = 0; s < ND; s++) begin
         @(negedge clk);
         g_an[s] = bus.an; g_seg[s] = bus.seg; g_dp[s] = bus.dp_n;
         @(negedge clk);
         @(negedge clk);
         o_an[s] = bus.an; o_sa[s] = bus.seg; o_da[s] = bus.dp_n;
         repeat (5) @(negedge clk);
         o_anb[s] = bus.an; o_sb[s] = bus.seg; o_db[s] = bus.dp_n;
      end
      tick_end = bus.frame_tick;
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      bus.value = v; bus.dp = d; bus.blank = b; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.frame_tick === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      exp_t e;
      logic [3:0] m;
      bus.value = '0; bus.dp = '0; bus.blank = '0; bus.load = 1'b0;
      fbus.value = '0; fbus.dp = '0; fbus.blank = '0; fbus.load = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.an, bus.seg, bus.dp_n, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state an=%b seg=%b dp_n=%b tick=%b want 1111 1111111 1 0",
                  bus.an, bus.seg, bus.dp_n, bus.frame_tick);
      end
      m = lzb_mask(16'h0000);
      for (int t = 1; t <= 40; t++) begin
         int c, sl;
         c  = (t - 1) % RD;
         sl = ((t - 1) / RD) % ND;
         if (c < GD) e = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1};
         else        e = '{an: ~(4'b0001 << sl), seg: m[sl] ? 7'h7F : 7'b1000000, dp_n: 1'b1};
         sb.push_back(e);
      end
      rst_n = 1'b1;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({bus.an, bus.seg, bus.dp_n} !== e) begin
            errors++;
            $display("FAIL reset_scan cycle %0d an=%b seg=%b dp_n=%b want an=%b seg=%b dp_n=%b",
                     t, bus.an, bus.seg, bus.dp_n, e.an, e.seg, e.dp_n);
         end
         checks++;
         if (bus.frame_tick !== (t % 32 == 0)) begin
            errors++;
            $display("FAIL reset_tick cycle %0d got %b want %b", t, bus.frame_tick, (t % 32 == 0));
         end
      end
   endtask

   task automatic test_decode();
      bit ok;
      exp_t e;
      do_load(16'h12AF, 4'b0000, 4'b0000);
      wait_tick(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL decode_wait got timeout want frame_tick"); end
      push_frame(16'h12AF, 4'b0000, 4'b0000);
      capture_frame();
      for (int s = 0; s < ND; s++) begin
         e = sb.pop_front();
         checks++;
         if ({o_an[s], o_sa[s], o_da[s]} !== e || {o_anb[s], o_sb[s], o_db[s]} !== e) begin
            errors++;
            $display("FAIL decode slot%0d got an=%b/%b seg=%b/%b dp_n=%b/%b want an=%b seg=%b dp_n=%b",
                     s, o_an[s], o_anb[s], o_sa[s], o_sb[s], o_da[s], o_db[s], e.an, e.seg, e.dp_n);
         end
         checks++;
         if ({g_an[s], g_seg[s], g_dp[s]} !== 12'hFFF) begin
            errors++;
            $display("FAIL decode_guard slot%0d got an=%b seg=%b dp_n=%b want all dark",
                     s, g_an[s], g_seg[s], g_dp[s]);
         end
      end
      checks++;
      if (tick_end !== 1'b1) begin errors++; $display("FAIL decode_period got tick=%b want 1", tick_end); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      exp_t e;
      wait_tick(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_wait got timeout want frame_tick"); end
      push_frame(16'h12AF, 4'b0000, 4'b0000);
      push_frame(16'h5678, 4'b0000, 4'b0000);
      fork
         capture_frame();
         begin
            repeat (10) @(negedge clk);
            do_load(16'h1234, 4'b0000, 4'b0000);
            @(negedge clk);
            do_load(16'h5678, 4'b0000, 4'b0000);
         end
      join
      for (int f = 0; f < 2; f++) begin
         if (f == 1) capture_frame();
         for (int s = 0; s < ND; s++) begin
            e = sb.pop_front();
            checks++;
            if ({o_an[s], o_sa[s], o_da[s]} !== e || {o_anb[s], o_sb[s], o_db[s]} !== e) begin
               errors++;
               $display("FAIL b2b frame%0d slot%0d got seg=%b/%b an=%b want seg=%b an=%b",
                        f, s, o_sa[s], o_sb[s], o_an[s], e.seg, e.an);
            end
         end
      end
   endtask

   task automatic test_boundary_load();
      exp_t e;
      push_frame(16'h5678, 4'b0000, 4'b0000);
      push_frame(16'hBEEF, 4'b0000, 4'b0000);
      push_frame(16'hBEEF, 4'b0000, 4'b0000);
      // The 31st cycle after the tick holds the last-slot/last-count state,
      // so the load lands on the boundary edge.
      fork
         capture_frame();
         begin
            repeat (31) @(negedge clk);
            do_load(16'hBEEF, 4'b0000, 4'b0000);
         end
      join
      for (int f = 0; f < 3; f++) begin
         if (f != 0) capture_frame();
         for (int s = 0; s < ND; s++) begin
            e = sb.pop_front();
            checks++;
            if ({o_an[s], o_sa[s], o_da[s]} !== e || {o_anb[s], o_sb[s], o_db[s]} !== e) begin
               errors++;
               $display("FAIL boundary frame%0d slot%0d got seg=%b/%b an=%b want seg=%b an=%b",
                        f, s, o_sa[s], o_sb[s], o_an[s], e.seg, e.an);
            end
         end
         checks++;
         if (tick_end !== 1'b1) begin
            errors++;
            $display("FAIL boundary_period frame%0d got tick=%b want 1", f, tick_end);
         end
      end
   endtask

   task automatic test_dp_blank();
      bit ok;
      exp_t e;
      logic [3:0] dps[2];
      dps[0] = 4'b0100;
      dps[1] = 4'b0010;
      for (int f = 0; f < 2; f++) begin
         do_load(16'h8888, dps[f], 4'b0010);
         wait_tick(ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL dp_blank_wait got timeout want frame_tick"); end
         push_frame(16'h8888, dps[f], 4'b0010);
         capture_frame();
         for (int s = 0; s < ND; s++) begin
            e = sb.pop_front();
            checks++;
            if ({o_an[s], o_sa[s], o_da[s]} !== e || {o_anb[s], o_sb[s], o_db[s]} !== e) begin
               errors++;
               $display("FAIL dp_blank case%0d slot%0d got seg=%b dp_n=%b want seg=%b dp_n=%b",
                        f, s, o_sa[s], o_da[s], e.seg, e.dp_n);
            end
            checks++;
            if ({g_an[s], g_seg[s], g_dp[s]} !== 12'hFFF) begin
               errors++;
               $display("FAIL dp_blank_guard slot%0d got an=%b seg=%b dp_n=%b want all dark",
                        s, g_an[s], g_seg[s], g_dp[s]);
            end
         end
      end
   endtask

   task automatic test_zero_blanking();
      bit ok;
      exp_t e;
      logic [15:0] vals[2];
      vals[0] = 16'h0030;
      vals[1] = 16'h0000;
      for (int f = 0; f < 2; f++) begin
         do_load(vals[f], 4'b0000, 4'b0000);
         wait_tick(ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL zeros_wait got timeout want frame_tick"); end
         push_frame(vals[f], 4'b0000, 4'b0000);
         capture_frame();
         for (int s = 0; s < ND; s++) begin
            e = sb.pop_front();
            checks++;
            if ({o_an[s], o_sa[s], o_da[s]} !== e || {o_anb[s], o_sb[s], o_db[s]} !== e) begin
               errors++;
               $display("FAIL zeros value=%h slot%0d got seg=%b want seg=%b", vals[f], s, o_sa[s], e.seg);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      exp_t e;
      do_load(16'h7777, 4'b1111, 4'b0000);   // left pending, must be discarded
      repeat (5) @(negedge clk);
      checks++;
      if (bus.an !== 4'b1110) begin
         errors++;
         $display("FAIL midreset_pre got an=%b want 1110", bus.an);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.an, bus.seg, bus.dp_n, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL midreset_dark an=%b seg=%b dp_n=%b tick=%b want 1111 1111111 1 0",
                  bus.an, bus.seg, bus.dp_n, bus.frame_tick);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_tick(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL midreset_wait got timeout want frame_tick"); end
      push_frame(16'h0000, 4'b0000, 4'b0000);
      capture_frame();
      for (int s = 0; s < ND; s++) begin
         e = sb.pop_front();
         checks++;
         if ({o_an[s], o_sa[s], o_da[s]} !== e) begin
            errors++;
            $display("FAIL midreset slot%0d got seg=%b dp_n=%b want seg=%b dp_n=%b",
                     s, o_sa[s], o_da[s], e.seg, e.dp_n);
         end
      end
   endtask

   task automatic test_fast_scan();
      bit ok;
      exp_t e;
      fbus.value = 16'h4321; fbus.dp = 4'b1000; fbus.blank = 4'b0000; fbus.load = 1'b1;
      @(negedge clk);
      fbus.load = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (fbus.frame_tick === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL fast_wait got timeout want frame_tick"); end
      for (int s = 0; s < ND; s++) begin
         e.an   = ~(4'b0001 << s);
         e.seg  = hex2seg(4'(s + 1));
         e.dp_n = (s != 3);
         sb.push_back(e);
      end
      for (int s = 0; s < ND; s++) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({fbus.an, fbus.seg, fbus.dp_n} !== e) begin
            errors++;
            $display("FAIL fast slot%0d got an=%b seg=%b dp_n=%b want an=%b seg=%b dp_n=%b",
                     s, fbus.an, fbus.seg, fbus.dp_n, e.an, e.seg, e.dp_n);
         end
      end
      checks++;
      if (fbus.frame_tick !== 1'b1) begin
         errors++;
         $display("FAIL fast_tick got %b want 1", fbus.frame_tick);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_boundary_load();
      test_dp_blank();
      test_zero_blanking();
      test_reset_mid();
      test_fast_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssd_scan_mux.md
# ssd_scan_mux

Parametrised, time-multiplexed seven-segment display driver. Takes a packed word of NUM_DIGITS hex nibbles plus per-digit decimal-point and blank flags, decodes each nibble to active-low segments, and scans the digits one at a time through active-low anode enables. A double-buffered load path keeps a frame from mixing old and new values. A guard gap between digits suppresses ghosting. It sits between the datapath registers and the board's common-anode display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 50000, clock cycles per digit slot (must be > GUARD)
- GUARD, 2, cycles at slot start with all anodes off (0 disables the gap)

- clk  in  1  rising-edge system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  4*NUM_DIGITS  hex nibbles; digit k = value[4k+3:4k]; digit 0 is rightmost
- dp  in  NUM_DIGITS  decimal-point request per digit, 1 = lit
- blank  in  NUM_DIGITS  force digit dark, 1 = blank
- load  in  1  one-cycle strobe capturing value/dp/blank into shadow registers
- seg  out  7  segments a..g on bits 0..6, active-low
- dp_n  out  1  decimal point, active-low
- an  out  NUM_DIGITS  digit enables, active-low, at most one low
- frame_tick  out  1  one-cycle pulse when the display registers update (scan wraps to digit 0)

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, idx advances; after NUM_DIGITS-1, idx returns to 0 (frame boundary).
- Shadow registers capture value/dp/blank on every cycle with load=1; the last load wins. A pending flag is set by load.
- At a frame boundary with pending=1: shadow copies into display registers, pending clears, frame_tick=1. If there is no pending load, display registers hold and frame_tick still pulses.
- Load coinciding with a frame boundary: the incoming inputs go directly into the display registers and pending stays 0. The load takes effect for the new frame.
- Decode (digit nibble -> seg, active-low, bit order g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blanked digit: seg=1111111; dp_n still follows dp.
- Guard: while cnt<GUARD, an=all ones, seg=1111111, dp_n=1. Otherwise an[idx]=0 and all other anode bits are 1.

## Timing
- All outputs are registered. Each output reflects the cnt/idx state of the previous cycle, so there is 1 cycle of latency.
- Reset (async assert, sync-released internally by the existing reset tree): cnt=0, idx=0, pending=0, shadow/display=0, an=all ones, seg=1111111, dp_n=1, frame_tick=0.
- First lit digit after reset: an[0] falls at clock GUARD+1.
- Load to display: worst case NUM_DIGITS*REFRESH_DIV cycles; best case 0 (coincident with the boundary).
- Reset mid-scan: outputs go dark immediately and asynchronously; the scan restarts from digit 0, and any pending load is discarded.
- REFRESH_DIV=1 with GUARD=0 is legal: idx advances every cycle.

## Configuration
- SSD_LZB_EN defined: leading-zero blanking on display registers.
  - Starting from digit NUM_DIGITS-1 and moving down, every digit with nibble 0 is blanked until the first nonzero nibble.
  - Digit 0 is never LZB-blanked.
  - dp is unaffected.
- SSD_LZB_EN undefined: zeros display as "0"; only the blank input darkens digits.

## Structure
- Package ssd_pkg holds:
  - the 16-entry segment pattern constants
  - SEG_OFF (1111111)
  - a localparam function for the counter width, clog2(REFRESH_DIV)
- Sub-module ssd_hex_dec is pure combinational: 4-bit nibble plus blank in, 7-bit active-low seg out. Instantiate it once on the muxed current digit.

## Test plan
- Reset release, NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2 -> an=1111 for cycles 1-2; an=1110 from cycle 3 through 8; anode order 1110,1101,1011,0111 repeats.
- load with value=16'h12AF and no blanks -> after the next frame_tick, slot 0 shows seg=0001110 (F), slot 1 shows 0001000 (A), slot 2 shows 0100100, slot 3 shows 1111001.
- load mid-frame with 16'h1234, then 16'h5678 two cycles later -> the next frame shows only 5678, never mixed with 1234 within a frame.
- load on the exact frame-boundary cycle with 16'hBEEF -> that frame shows BEEF; the pending flag stays 0 and the following frame_tick causes no change.
- dp=4'b0100, blank=4'b0010 -> slot 2 has dp_n=0; slot 1 has seg=1111111; guard cycles always have dp_n=1.
- With SSD_LZB_EN, value=16'h0030 -> slots 3 and 2 are dark, slot 1 shows 3, slot 0 shows 0. Value 16'h0000 -> only slot 0 is lit, showing 0.
